// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FWFT FIFO with guarded push/pop,
// programmable almost-full/almost-empty thresholds, sticky error flags,
// synchronous flush and one-cycle full/empty rising-edge pulses.
//
// Optional feature macro: FIFO_HWM_EN builds a high-water-mark register.
// When the macro is undefined, hwm is tied to 0.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   clear                    synchronous flush (thresholds kept)
//   push, datain             write request / data
//   pop, dataout             read request / head-of-queue data (FWFT)
//   cfg_we, cfg_af, cfg_ae   threshold register load
//   count                    registered occupancy 0..DEPTH
//   full, empty              count == DEPTH / count == 0
//   almost_full/empty        count >= af_level / count <= ae_level
//   full_rise, empty_rise    one-cycle 0->1 pulses of full / empty
//   overflow, underflow      sticky error flags, cleared by err_clr
//   err_clr                  clears error flags (and hwm)
//   hwm                      high-water mark of count
module sync_fifo_flagged #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_RESET = 12,
    parameter int AE_RESET = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [WIDTH-1:0]  datain,
    input  logic              pop,
    output logic [WIDTH-1:0]  dataout,
    input  logic              cfg_we,
    input  logic [ADDR_W:0]   cfg_af,
    input  logic [ADDR_W:0]   cfg_ae,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              full_rise,
    output logic              empty_rise,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic [ADDR_W:0]   hwm
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   af_level, ae_level;
    logic [ADDR_W:0]   count_next;
    logic              full_q, empty_q;
    logic              push_ok, pop_ok;

    // Flags come only from the registered count: no comb path from push/pop.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_level);
    assign almost_empty = (count <= ae_level);
    assign full_rise    = full & ~full_q;
    assign empty_rise   = empty & ~empty_q;
    assign dataout      = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so push is allowed while full
    // as long as it is paired with a pop.
    always_comb begin
        push_ok = push & (~full | pop);
        pop_ok  = pop & ~empty;
        if (clear)
            count_next = '0;
        else
            count_next = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            af_level  <= (ADDR_W+1)'(AF_RESET);
            ae_level  <= (ADDR_W+1)'(AE_RESET);
        end else begin
            count   <= count_next;
            full_q  <= full;
            empty_q <= empty;
            if (cfg_we) begin
                af_level <= cfg_af;
                ae_level <= cfg_ae;
            end
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
            // Set beats clear-request; flush suppresses new errors.
            if (!clear && push && full && !pop) overflow <= 1'b1;
            else if (err_clr)                   overflow <= 1'b0;
            if (!clear && pop && empty)         underflow <= 1'b1;
            else if (err_clr)                   underflow <= 1'b0;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push_ok) mem[wr_ptr] <= datain;
    end

`ifdef FIFO_HWM_EN
    logic [ADDR_W:0] hwm_r;
    // err_clr zeroes the mark; it re-acquires the live count next cycle.
    always_ff @(posedge clk) begin
        if (rst || err_clr)
            hwm_r <= '0;
        else if (count_next > hwm_r)
            hwm_r <= count_next;
    end
    assign hwm = hwm_r;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_flagged.sv
module tb_sync_fifo_flagged;
    logic       clk = 0, rst = 1, clear = 0, push = 0, pop = 0;
    logic       cfg_we = 0, err_clr = 0;
    logic [7:0] datain = 0, dataout;
    logic [4:0] cfg_af = 0, cfg_ae = 0, count, hwm;
    logic full, empty, almost_full, almost_empty, full_rise, empty_rise;
    logic overflow, underflow;

    sync_fifo_flagged dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .datain(datain),
        .pop(pop), .dataout(dataout), .cfg_we(cfg_we), .cfg_af(cfg_af),
        .cfg_ae(cfg_ae), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .full_rise(full_rise), .empty_rise(empty_rise), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr), .hwm(hwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ps, pp, cl, ec, cw;
        logic [7:0] d;
        logic [4:0] caf, cae;
        bit         cd;
        logic [7:0] edout;
        logic [4:0] ecnt;
        logic [7:0] eflg;  // {full,empty,af,ae,fr,er,ovf,udf}
    } vec_t;

    vec_t vq[$];
    int checks = 0, errors = 0;

    function automatic logic [7:0] fl(bit f, bit e, bit af, bit ae, bit fr,
                                      bit er, bit ov, bit ud);
        return {f, e, af, ae, fr, er, ov, ud};
    endfunction

    function automatic void add(bit ps, bit pp, bit cl, bit ec, bit cw,
                                logic [7:0] d, logic [4:0] caf, logic [4:0] cae,
                                bit cd, logic [7:0] edout, logic [4:0] ecnt,
                                logic [7:0] eflg);
        vec_t v;
        v.ps = ps; v.pp = pp; v.cl = cl; v.ec = ec; v.cw = cw; v.d = d;
        v.caf = caf; v.cae = cae; v.cd = cd; v.edout = edout;
        v.ecnt = ecnt; v.eflg = eflg;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] wrap_seq(int j);
        return (j < 16) ? 8'(8'h10 + j) : 8'(8'h20 + j - 16);
    endfunction

    task automatic step(bit ps, bit pp, bit cl, bit ec, logic [7:0] d);
        push = ps; pop = pp; clear = cl; err_clr = ec; datain = d; cfg_we = 0;
        @(posedge clk); #1;
    endtask

    logic [7:0] flg;
    logic [4:0] hwm_exp;

    initial begin
        // Phase 1: 16 pushes 0x00..0x0F
        for (int i = 0; i < 16; i++)
            add(1,0,0,0,0, 8'(i), 0,0, 1, 8'h00, 5'(i+1),
                fl(i==15, 0, (i+1)>=12, (i+1)<=4, i==15, 0, 0, 0));
        // Phase 2: overflow while full, set wins over err_clr, then clear
        add(1,0,0,0,0, 8'hAA, 0,0, 1, 8'h00, 16, fl(1,0,1,0,0,0,1,0));
        add(0,0,0,0,0, 8'h00, 0,0, 1, 8'h00, 16, fl(1,0,1,0,0,0,1,0));
        add(1,0,0,1,0, 8'hAB, 0,0, 1, 8'h00, 16, fl(1,0,1,0,0,0,1,0));
        add(0,0,0,1,0, 8'h00, 0,0, 1, 8'h00, 16, fl(1,0,1,0,0,0,0,0));
        // Phase 3: 16 pops, in-order data, empty_rise at the end
        for (int i = 0; i < 16; i++)
            add(0,1,0,0,0, 8'h00, 0,0, i<15, 8'(i+1), 5'(15-i),
                fl(0, i==15, (15-i)>=12, (15-i)<=4, 0, i==15, 0, 0));
        // Phase 4: pop+push while empty -> push accepted, underflow
        add(1,1,0,0,0, 8'h55, 0,0, 1, 8'h55, 1, fl(0,0,0,1,0,0,0,1));
        add(0,0,0,1,0, 8'h00, 0,0, 1, 8'h55, 1, fl(0,0,0,1,0,0,0,0));
        add(0,1,0,0,0, 8'h00, 0,0, 0, 8'h00, 0, fl(0,1,0,1,0,1,0,0));
        // Phase 5: fill with 0x10.., then 20 push+pop cycles across wrap
        for (int i = 0; i < 16; i++)
            add(1,0,0,0,0, 8'(8'h10+i), 0,0, 1, 8'h10, 5'(i+1),
                fl(i==15, 0, (i+1)>=12, (i+1)<=4, i==15, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            add(1,1,0,0,0, 8'(8'h20+i), 0,0, 1, wrap_seq(i+1), 16,
                fl(1,0,1,0,0,0,0,0));
        // Phase 6: clear ignores push/pop; thresholds af=3 ae=1 and retention
        add(1,1,1,0,0, 8'hEE, 0,0, 0, 8'h00, 0, fl(0,1,0,1,0,1,0,0));
        add(0,0,0,0,1, 8'h00, 3,1, 0, 8'h00, 0, fl(0,1,0,1,0,0,0,0));
        add(1,0,0,0,0, 8'h30, 0,0, 1, 8'h30, 1, fl(0,0,0,1,0,0,0,0));
        add(1,0,0,0,0, 8'h31, 0,0, 1, 8'h30, 2, fl(0,0,0,0,0,0,0,0));
        add(1,0,0,0,0, 8'h32, 0,0, 1, 8'h30, 3, fl(0,0,1,0,0,0,0,0));
        add(1,1,1,0,0, 8'hEE, 0,0, 0, 8'h00, 0, fl(0,1,0,1,0,1,0,0));
        add(0,1,1,0,0, 8'h00, 0,0, 0, 8'h00, 0, fl(0,1,0,1,0,0,0,0));
        add(1,0,0,0,0, 8'h33, 0,0, 1, 8'h33, 1, fl(0,0,0,1,0,0,0,0));
        add(1,0,0,0,0, 8'h34, 0,0, 1, 8'h33, 2, fl(0,0,0,0,0,0,0,0));
        add(1,0,0,0,0, 8'h35, 0,0, 1, 8'h33, 3, fl(0,0,1,0,0,0,0,0));
        // Threshold above DEPTH: almost_full never asserts
        add(0,0,0,0,1, 8'h00, 17,0, 1, 8'h33, 3, fl(0,0,0,0,0,0,0,0));

        // Reset state
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", count, 0);
        chk("rst flags",
            fl(full, empty, almost_full, almost_empty, full_rise, empty_rise,
               overflow, underflow), fl(0,1,0,1,0,0,0,0));
        chk("rst hwm", hwm, 0);
        rst = 0;

        foreach (vq[i]) begin
            push = vq[i].ps; pop = vq[i].pp; clear = vq[i].cl;
            err_clr = vq[i].ec; cfg_we = vq[i].cw; datain = vq[i].d;
            cfg_af = vq[i].caf; cfg_ae = vq[i].cae;
            @(posedge clk); #1;
            flg = fl(full, empty, almost_full, almost_empty, full_rise,
                     empty_rise, overflow, underflow);
            chk($sformatf("v%0d count", i), count, vq[i].ecnt);
            chk($sformatf("v%0d flags", i), flg, vq[i].eflg);
            if (vq[i].cd) chk($sformatf("v%0d dataout", i), dataout, vq[i].edout);
        end
        cfg_we = 0;

        // High-water mark sequence from a fresh reset (thresholds back to 12/4)
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("hwm rst count", count, 0);
        for (int k = 0; k < 9; k++) step(1,0,0,0, 8'(8'h40+k));
        chk("hwm af at 9 (reset level 12)", almost_full, 0);
        for (int k = 0; k < 5; k++) step(0,1,0,0, 8'h00);
        for (int k = 0; k < 2; k++) step(1,0,0,0, 8'(8'h50+k));
        chk("hwm seq count", count, 6);
        chk("hwm seq dataout", dataout, 8'h45);
`ifdef FIFO_HWM_EN
        hwm_exp = 9;
`else
        hwm_exp = 0;
`endif
        chk("hwm peak", hwm, hwm_exp);
        step(0,0,0,1, 8'h00);
        chk("hwm after err_clr", hwm, 0);
        step(0,0,0,0, 8'h00);
`ifdef FIFO_HWM_EN
        hwm_exp = 6;
`else
        hwm_exp = 0;
`endif
        chk("hwm reacquire", hwm, hwm_exp);
        step(0,0,1,0, 8'h00);
        chk("hwm kept by clear", hwm, hwm_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
